// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC widths, arctangent table, gain and quadrant constants.
// CORDIC_VEC_GAIN_COMP_EN adds the SCALE state to the vectoring FSM encoding.
package cordic_pkg;
    localparam int WIDTH       = 16;
    localparam int ANGLE_WIDTH = 32;
    localparam int XW          = WIDTH + 3;
    localparam int CW          = $clog2(WIDTH);
    localparam logic [13:0] GAIN = 14'b10011011011101;
    localparam logic [ANGLE_WIDTH-1:0] ANGLE_POS_90 = 32'h4000_0000;
    localparam logic [ANGLE_WIDTH-1:0] ANGLE_NEG_90 = 32'hC000_0000;
    // atan(2^-i) with 2^32 LSB = 360 degrees
    localparam logic [ANGLE_WIDTH-1:0] ATAN [WIDTH] = '{
        32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F29, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C
    };
    typedef enum logic [1:0] {
        IDLE,
        ITER,
`ifdef CORDIC_VEC_GAIN_COMP_EN
        SCALE,
`endif
        DONE
    } state_t;
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational iteration index to arctangent lookup.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [CW-1:0]          idx,
    output logic [ANGLE_WIDTH-1:0] atan
);
    assign atan = ATAN[idx];
endmodule

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC, magnitude and atan2 of (x,y).
// CORDIC_VEC_GAIN_COMP_EN adds a one-cycle gain compensation of the magnitude.
module cordic_vector
    import cordic_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH:0]   in_x,
    input  logic signed [WIDTH:0]   in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH+2:0]        out_mag,
    output logic [ANGLE_WIDTH-1:0]  out_angle
);
    state_t state, state_nxt;
    logic [CW-1:0] count;
    logic signed [XW-1:0] x, y, xs, ys, ex, ey;
    logic [ANGLE_WIDTH-1:0] z, atan_i;
    logic zero, y_neg;

    cordic_atan_rom u_rom (.idx(count), .atan(atan_i));

    assign ex    = XW'(in_x);
    assign ey    = XW'(in_y);
    assign xs    = x >>> count;
    assign ys    = y >>> count;
    assign y_neg = y[XW-1];

    always_comb begin
        state_nxt = state;
        if (state == IDLE && in_valid)
            state_nxt = ITER;
        if (state == ITER && count == CW'(WIDTH - 1))
`ifdef CORDIC_VEC_GAIN_COMP_EN
            state_nxt = SCALE;
        if (state == SCALE)
            state_nxt = DONE;
`else
            state_nxt = DONE;
`endif
        if (state == DONE && out_ready)
            state_nxt = IDLE;
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_mag   = (out_valid && !zero) ? $unsigned(x) : '0;
    assign out_angle = (out_valid && !zero) ? z : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_valid && in_ready) begin
                // left half-plane is folded into the right by a +/-90 degree pre-rotation
                count <= '0;
                zero  <= in_x == '0 && in_y == '0;
                x     <= ex[XW-1] ? (ey[XW-1] ? -ey : ey) : ex;
                y     <= ex[XW-1] ? (ey[XW-1] ? ex : -ex) : ey;
                z     <= ex[XW-1] ? (ey[XW-1] ? ANGLE_NEG_90 : ANGLE_POS_90) : '0;
            end else if (state == ITER) begin
                count <= count + CW'(1);
                x     <= y_neg ? x - ys : x + ys;
                y     <= y_neg ? y + xs : y - xs;
                z     <= y_neg ? z - atan_i : z + atan_i;
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            else if (state == SCALE)
                x <= XW'((34'(x) * 34'($signed({1'b0, GAIN}))) >>> 14);
`endif
        end
    end
endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: directed vectors with hand-computed magnitude and angle.
module tb_cordic_vector;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int LAT = 17, M1 = 16384, M45 = 23170, MBIG = 92682;
`else
    localparam int LAT = 16, M1 = 26981, M45 = 38156, MBIG = 152624;
`endif
    localparam int ATOL = 32'h10000;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready;
    logic signed [16:0] in_x, in_y;
    logic [18:0] out_mag;
    logic [31:0] out_angle;
    int passed = 0, total = 0;

    cordic_vector dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_mag(out_mag), .out_angle(out_angle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol);
        longint d;
        d = longint'(int'(got - exp));
        if (d < 0) d = -d;
        total++;
        if (d <= longint'(tol)) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (tol %0d)", tag, got, exp, tol);
    endtask

    task automatic send(input logic signed [16:0] vx, input logic signed [16:0] vy);
        in_x = vx;
        in_y = vy;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = 17'h0AAAA;
        in_y = 17'h15555;
    endtask

    task automatic wait_result(input string tag);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, lat, LAT, 0);
    endtask

    task automatic run_vec(input string tag, input logic signed [16:0] vx, input logic signed [16:0] vy,
                           input int emag, input int mtol, input logic [31:0] eang, input int atol);
        send(vx, vy);
        wait_result(tag);
        check({tag, ".mag"}, out_mag, emag, mtol);
        check({tag, ".ang"}, out_angle, eang, atol);
        @(posedge clk); #1;
    endtask

    initial begin
        int hits;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_x = '0;
        in_y = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst.in_ready", in_ready, 1, 0);
        check("rst.out_valid", out_valid, 0, 0);
        check("rst.mag", out_mag, 0, 0);
        check("rst.ang", out_angle, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_vec("x_pos", 16384, 0, M1, 4, 32'h0000_0000, ATOL);
        run_vec("y_pos", 0, 16384, M1, 8, 32'h4000_0000, ATOL);
        run_vec("x_neg", -16384, 0, M1, 8, 32'h8000_0000, ATOL);
        run_vec("q4_45", 16384, -16384, M45, 8, 32'hE000_0000, ATOL);
        run_vec("q3_big", -65536, -65536, MBIG, 8, 32'hA000_0000, ATOL);
        run_vec("zero", 0, 0, 0, 0, 32'h0, 0);

        out_ready = 1'b0;
        send(16384, 0);
        wait_result("bp");
        in_valid = 1'b1;
        in_x = 0;
        in_y = 16384;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp.valid", out_valid, 1, 0);
            check("bp.in_ready", in_ready, 0, 0);
            check("bp.mag", out_mag, M1, 4);
            check("bp.ang", out_angle, 0, ATOL);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.rel_valid", out_valid, 0, 0);
        check("bp.rel_ready", in_ready, 1, 0);
        hits = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check("bp.ignored", hits, 0, 0);

        send(16384, -16384);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.in_ready", in_ready, 1, 0);
        check("mid_rst.out_valid", out_valid, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        hits = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check("mid_rst.no_result", hits, 0, 0);
        run_vec("post_rst", -65536, -65536, MBIG, 8, 32'hA000_0000, ATOL);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
